ocx_tlx_cfg_resp_xmt: RTL and testbench

Transmit-side config data buffer for the TLX. Config read-response words from the config space are queued in a FIFO. The block then issues them to the framer as dcp1 data, gated by a dcp1 credit counter that the remote receiver replenishes. It is the sending end of the dcp1 config data path; its credit-return input is driven by the far side's `rcv_xmt_tl_crd_cfg_dcp1_valid`.

---
 rtl/ocx_tlx_cfg_resp_xmt.sv | 125 ++++++++++++
 tb/tb_ocx_tlx_cfg_resp_xmt.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ocx_tlx_cfg_resp_xmt.sv
// TLX transmit-side config response FIFO with dcp1 credit gating.
// Define OCX_TLX_CFG_XMT_PARITY_EN to store and check per-word even parity.
module ocx_tlx_cfg_resp_xmt #(
    parameter int addr_width   = 6,
    parameter int crd_width    = 4,
    parameter int init_credits = 8
) (
    input  logic                  tlx_clk,
    input  logic                  reset,
    input  logic                  cfg_resp_data_v,
    input  logic [31:0]           cfg_resp_data_bus,
    output logic                  tlx_cfg_resp_rdy,
    input  logic                  rcv_xmt_tl_crd_cfg_dcp1_valid,
    output logic                  xmt_cfg_dcp1_req,
    output logic [31:0]           xmt_cfg_dcp1_data,
    input  logic                  framer_cfg_dcp1_gnt,
    output logic [addr_width:0]   cfg_fifo_count,
    output logic [crd_width-1:0]  cfg_crd_count,
    output logic                  cfg_fifo_ovf_err,
    output logic                  cfg_crd_ovf_err,
    output logic                  xmt_cfg_dcp1_perr
);

`ifdef OCX_TLX_CFG_XMT_PARITY_EN
    localparam int DW = 33;
`else
    localparam int DW = 32;
`endif
    localparam int DEPTH = 2 ** addr_width;
    localparam logic [crd_width-1:0] CRD_INIT = crd_width'(init_credits);
    localparam logic [crd_width-1:0] CRD_MAX  = '1;

    logic [DW-1:0]          mem [DEPTH];
    logic [addr_width:0]    wr_ptr;
    logic [addr_width:0]    rd_ptr;
    logic [crd_width-1:0]   crd;
    logic                   empty;
    logic                   full;
    logic                   wr_en;
    logic                   gnt_en;
    logic                   ret;
    logic [DW-1:0]          wdata;
    logic [DW-1:0]          head;
    logic [crd_width-1:0]   crd_nxt;
    logic                   crd_ovf;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[addr_width] != rd_ptr[addr_width]) &&
                   (wr_ptr[addr_width-1:0] == rd_ptr[addr_width-1:0]);

    assign wr_en  = cfg_resp_data_v && !full;
    assign ret    = rcv_xmt_tl_crd_cfg_dcp1_valid;
    assign head   = mem[rd_ptr[addr_width-1:0]];

    assign xmt_cfg_dcp1_req  = !empty && (crd != '0);
    assign gnt_en            = framer_cfg_dcp1_gnt && xmt_cfg_dcp1_req;
    assign xmt_cfg_dcp1_data = head[31:0];
    assign tlx_cfg_resp_rdy  = !full;
    assign cfg_fifo_count    = wr_ptr - rd_ptr;
    assign cfg_crd_count     = crd;

`ifdef OCX_TLX_CFG_XMT_PARITY_EN
    assign wdata = {^cfg_resp_data_bus, cfg_resp_data_bus};
`else
    assign wdata = cfg_resp_data_bus;
`endif

    // Return and grant in the same cycle cancel; a return at max saturates.
    always_comb begin
        crd_nxt = crd;
        crd_ovf = 1'b0;
        if (ret && !gnt_en) begin
            if (crd == CRD_MAX) begin
                crd_ovf = 1'b1;
            end else begin
                crd_nxt = crd + 1'b1;
            end
        end else if (gnt_en && !ret) begin
            crd_nxt = crd - 1'b1;
        end
    end

    always_ff @(posedge tlx_clk) begin
        if (wr_en) begin
            mem[wr_ptr[addr_width-1:0]] <= wdata;
        end
    end

    always_ff @(posedge tlx_clk or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            crd              <= CRD_INIT;
            cfg_fifo_ovf_err <= 1'b0;
            cfg_crd_ovf_err  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (cfg_resp_data_v && full) begin
                cfg_fifo_ovf_err <= 1'b1;
            end
            if (gnt_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (crd_ovf) begin
                cfg_crd_ovf_err <= 1'b1;
            end
            crd <= crd_nxt;
        end
    end

`ifdef OCX_TLX_CFG_XMT_PARITY_EN
    always_ff @(posedge tlx_clk or posedge reset) begin
        if (reset) begin
            xmt_cfg_dcp1_perr <= 1'b0;
        end else if (gnt_en && ((^head[31:0]) != head[32])) begin
            xmt_cfg_dcp1_perr <= 1'b1;
        end
    end
`else
    assign xmt_cfg_dcp1_perr = 1'b0;
`endif

endmodule

// File: tb/tb_ocx_tlx_cfg_resp_xmt.sv
// Bench for ocx_tlx_cfg_resp_xmt: scoreboard of sent words plus directed state checks.
module tb_ocx_tlx_cfg_resp_xmt;

    logic        tlx_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_resp_data_v = 1'b0;
    logic [31:0] cfg_resp_data_bus = '0;
    logic        tlx_cfg_resp_rdy;
    logic        crd_ret = 1'b0;
    logic        xmt_cfg_dcp1_req;
    logic [31:0] xmt_cfg_dcp1_data;
    logic        gnt = 1'b0;
    logic [6:0]  cfg_fifo_count;
    logic [3:0]  cfg_crd_count;
    logic        cfg_fifo_ovf_err;
    logic        cfg_crd_ovf_err;
    logic        xmt_cfg_dcp1_perr;

    int checks = 0;
    int failures = 0;
    int mcnt = 0;
    int grants = 0;
    logic [31:0] sb [$];

    ocx_tlx_cfg_resp_xmt #(
        .addr_width(6),
        .crd_width(4),
        .init_credits(8)
    ) dut (
        .tlx_clk(tlx_clk),
        .reset(reset),
        .cfg_resp_data_v(cfg_resp_data_v),
        .cfg_resp_data_bus(cfg_resp_data_bus),
        .tlx_cfg_resp_rdy(tlx_cfg_resp_rdy),
        .rcv_xmt_tl_crd_cfg_dcp1_valid(crd_ret),
        .xmt_cfg_dcp1_req(xmt_cfg_dcp1_req),
        .xmt_cfg_dcp1_data(xmt_cfg_dcp1_data),
        .framer_cfg_dcp1_gnt(gnt),
        .cfg_fifo_count(cfg_fifo_count),
        .cfg_crd_count(cfg_crd_count),
        .cfg_fifo_ovf_err(cfg_fifo_ovf_err),
        .cfg_crd_ovf_err(cfg_crd_ovf_err),
        .xmt_cfg_dcp1_perr(xmt_cfg_dcp1_perr)
    );

    always #5 tlx_clk = ~tlx_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake completes at the next posedge; inputs are stable from posedge+1.
    always @(negedge tlx_clk) begin
        if (!reset && xmt_cfg_dcp1_req && gnt) begin
            grants++;
            mcnt--;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: got %0h expected none",
                         xmt_cfg_dcp1_data);
            end else begin
                chk("dcp1_data", xmt_cfg_dcp1_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge tlx_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gnt = 1'b0;
        crd_ret = 1'b0;
        cfg_resp_data_v = 1'b0;
        sb.delete();
        mcnt = 0;
        grants = 0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        cfg_resp_data_v = 1'b1;
        cfg_resp_data_bus = d;
        if (mcnt < 64) begin
            sb.push_back(d);
            mcnt++;
        end
        tick();
        cfg_resp_data_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_count", 32'(cfg_fifo_count), 0);
        chk("rst_req", 32'(xmt_cfg_dcp1_req), 0);
        chk("rst_rdy", 32'(tlx_cfg_resp_rdy), 1);
        chk("rst_crd", 32'(cfg_crd_count), 8);
        chk("rst_errs", {29'd0, cfg_fifo_ovf_err, cfg_crd_ovf_err,
                         xmt_cfg_dcp1_perr}, 0);

        // single word
        wr(32'hDEAD_BEEF);
        chk("t1_req", 32'(xmt_cfg_dcp1_req), 1);
        chk("t1_data", xmt_cfg_dcp1_data, 32'hDEAD_BEEF);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("t1_count", 32'(cfg_fifo_count), 0);
        chk("t1_crd", 32'(cfg_crd_count), 7);
        chk("t1_req0", 32'(xmt_cfg_dcp1_req), 0);

        // grant with no request is ignored
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("nogrant_crd", 32'(cfg_crd_count), 7);
        chk("nogrant_cnt", 32'(cfg_fifo_count), 0);

        // fill to full, overflow drop
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wr(32'(i));
            if (i == 62) chk("rdy_before_full", 32'(tlx_cfg_resp_rdy), 1);
        end
        chk("full_rdy", 32'(tlx_cfg_resp_rdy), 0);
        chk("full_count", 32'(cfg_fifo_count), 64);
        chk("full_ovf0", 32'(cfg_fifo_ovf_err), 0);
        wr(32'h55);
        chk("ovf_err", 32'(cfg_fifo_ovf_err), 1);
        chk("ovf_count", 32'(cfg_fifo_count), 64);
        gnt = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        gnt = 1'b0;
        chk("drain8_count", 32'(cfg_fifo_count), 56);
        chk("drain8_rdy", 32'(tlx_cfg_resp_rdy), 1);
        chk("ovf_sticky", 32'(cfg_fifo_ovf_err), 1);

        // credit exhaustion and replenish
        do_reset();
        for (int i = 0; i < 10; i++) wr(32'hA000_0000 + 32'(i));
        gnt = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("exh_grants", 32'(grants), 8);
        chk("exh_req", 32'(xmt_cfg_dcp1_req), 0);
        chk("exh_crd", 32'(cfg_crd_count), 0);
        chk("exh_count", 32'(cfg_fifo_count), 2);
        crd_ret = 1'b1;
        tick();
        crd_ret = 1'b0;
        chk("ret_req", 32'(xmt_cfg_dcp1_req), 1);
        tick();
        gnt = 1'b0;
        chk("ret_grants", 32'(grants), 9);
        chk("ret_count", 32'(cfg_fifo_count), 1);
        chk("ret_crd", 32'(cfg_crd_count), 0);

        // simultaneous return and grant at crd=3
        do_reset();
        for (int i = 0; i < 6; i++) wr(32'h0BAD_0000 + 32'(i));
        gnt = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        gnt = 1'b0;
        chk("c3_crd", 32'(cfg_crd_count), 3);
        gnt = 1'b1;
        crd_ret = 1'b1;
        tick();
        gnt = 1'b0;
        crd_ret = 1'b0;
        chk("both_crd", 32'(cfg_crd_count), 3);
        chk("both_count", 32'(cfg_fifo_count), 0);

        // credit saturation
        do_reset();
        crd_ret = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        crd_ret = 1'b0;
        chk("crd_max", 32'(cfg_crd_count), 15);
        chk("crd_ovf0", 32'(cfg_crd_ovf_err), 0);
        crd_ret = 1'b1;
        tick();
        crd_ret = 1'b0;
        chk("crd_sat", 32'(cfg_crd_count), 15);
        chk("crd_ovf", 32'(cfg_crd_ovf_err), 1);

        // asynchronous reset mid-transfer
        for (int i = 0; i < 3; i++) wr(32'hC0DE_0000 + 32'(i));
        chk("pre_rst_count", 32'(cfg_fifo_count), 3);
        @(negedge tlx_clk);
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(cfg_fifo_count), 0);
        chk("arst_crd", 32'(cfg_crd_count), 8);
        chk("arst_ovf", 32'(cfg_crd_ovf_err), 0);
        do_reset();

        // parity
        wr(32'h1234_5678);
`ifdef OCX_TLX_CFG_XMT_PARITY_EN
        dut.mem[0] = dut.mem[0] ^ 33'h1;
        void'(sb.pop_front());
        sb.push_back(32'h1234_5679);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("perr_set", 32'(xmt_cfg_dcp1_perr), 1);
`else
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("perr_tied", 32'(xmt_cfg_dcp1_perr), 0);
`endif
        chk("end_sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
